// File: rtl/mem_access_unit_if.sv
// ============================================================================
// Module  : mem_access_unit_if
// Brief   : EX->MEM pipe, data-memory bus and MEM->WB pipe signals of the
//           MEM-stage load/store unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_access_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_op;
    logic [31:0] in_alu_y;
    logic [31:0] in_store;
    logic [4:0]  in_wreg;
    logic        flush;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_wreg;
    logic [1:0]  out_exc;
    logic [31:0] out_badvaddr;

    // slave: the load/store unit itself
    modport slave (
        input  in_valid, in_op, in_alu_y, in_store, in_wreg, flush,
               data_addr_ok, data_data_ok, data_rdata, out_ready,
        output in_ready, data_req, data_wr, data_wen, data_addr, data_wdata,
               out_valid, out_result, out_wreg, out_exc, out_badvaddr
    );

    // master: the surrounding pipeline and memory
    modport master (
        output in_valid, in_op, in_alu_y, in_store, in_wreg, flush,
               data_addr_ok, data_data_ok, data_rdata, out_ready,
        input  in_ready, data_req, data_wr, data_wen, data_addr, data_wdata,
               out_valid, out_result, out_wreg, out_exc, out_badvaddr
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module  : mem_access_unit
// Brief   : MEM-stage load/store unit: SRAM-like bus requests, load alignment
//           and extension, alignment/timeout exceptions, flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int TIMEOUT_CYC = 255
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    mem_access_unit_if.slave  bus
);

    localparam logic [7:0] c_op_lb  = 8'b1110_0000;
    localparam logic [7:0] c_op_lh  = 8'b1110_0001;
    localparam logic [7:0] c_op_lw  = 8'b1110_0011;
    localparam logic [7:0] c_op_lbu = 8'b1110_0100;
    localparam logic [7:0] c_op_lhu = 8'b1110_0101;
    localparam logic [7:0] c_op_sb  = 8'b1110_1000;
    localparam logic [7:0] c_op_sh  = 8'b1110_1001;
    localparam logic [7:0] c_op_sw  = 8'b1110_1011;
    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_flushed;
    logic [31:0] r_addr;
    logic [7:0]  r_op;
    logic        r_wr;
    logic [3:0]  r_wen;
    logic [31:0] r_wdata;
    logic [4:0]  r_wreg;
    logic        r_out_valid;
    logic [31:0] r_out_result;
    logic [4:0]  r_out_wreg;
    logic [1:0]  r_out_exc;
    logic [31:0] r_out_badvaddr;

    logic        w_is_load, w_is_store, w_is_mem, w_misalign, w_accept;
    logic [3:0]  w_wen;
    logic [31:0] w_wdata, w_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_busy, w_done_ok, w_tmo;

    assign bus.in_ready     = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready) && !bus.flush;
    assign w_accept         = bus.in_valid && bus.in_ready;
    assign bus.data_req     = (r_state == S_REQ);
    assign bus.data_wr      = r_wr;
    assign bus.data_wen     = r_wen;
    assign bus.data_addr    = {r_addr[31:2], 2'b00};
    assign bus.data_wdata   = r_wdata;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_result   = r_out_result;
    assign bus.out_wreg     = r_out_wreg;
    assign bus.out_exc      = r_out_exc;
    assign bus.out_badvaddr = r_out_badvaddr;

    // Decode of the incoming instruction: class, alignment and store lanes
    always_comb begin
        w_is_load  = (bus.in_op == c_op_lb) || (bus.in_op == c_op_lbu) || (bus.in_op == c_op_lh)
                  || (bus.in_op == c_op_lhu) || (bus.in_op == c_op_lw);
        w_is_store = (bus.in_op == c_op_sb) || (bus.in_op == c_op_sh) || (bus.in_op == c_op_sw);
        w_is_mem   = w_is_load || w_is_store;
        w_misalign = 1'b0;
        w_wen      = 4'b0000;
        w_wdata    = 32'd0;
        case (bus.in_op)
            c_op_lw:            w_misalign = (bus.in_alu_y[1:0] != 2'b00);
            c_op_lh, c_op_lhu:  w_misalign = bus.in_alu_y[0];
            c_op_sb: begin
                w_wen   = 4'b0001 << bus.in_alu_y[1:0];
                w_wdata = {4{bus.in_store[7:0]}};
            end
            c_op_sh: begin
                w_misalign = bus.in_alu_y[0];
                w_wen      = bus.in_alu_y[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{bus.in_store[15:0]}};
            end
            c_op_sw: begin
                w_misalign = (bus.in_alu_y[1:0] != 2'b00);
                w_wen      = 4'b1111;
                w_wdata    = bus.in_store;
            end
            default: ;
        endcase
    end

    // Load data alignment and extension from the latched address and op
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = bus.data_rdata[7:0];
            2'd1:    w_byte = bus.data_rdata[15:8];
            2'd2:    w_byte = bus.data_rdata[23:16];
            default: w_byte = bus.data_rdata[31:24];
        endcase
        w_half = r_addr[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
        case (r_op)
            c_op_lb:  w_load = {{24{w_byte[7]}}, w_byte};
            c_op_lbu: w_load = {24'd0, w_byte};
            c_op_lh:  w_load = {{16{w_half[15]}}, w_half};
            c_op_lhu: w_load = {16'd0, w_half};
            c_op_lw:  w_load = bus.data_rdata;
            default:  w_load = 32'd0;
        endcase
    end

    assign w_busy    = (r_state == S_REQ) || (r_state == S_WAIT);
    assign w_done_ok = ((r_state == S_REQ) && bus.data_addr_ok && bus.data_data_ok)
                    || ((r_state == S_WAIT) && bus.data_data_ok);
    // A real completion in the last allowed cycle wins over the timeout
    assign w_tmo     = w_busy && !w_done_ok && (r_cnt == c_tmo_last);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_cnt          <= 8'd0;
            r_flushed      <= 1'b0;
            r_addr         <= 32'd0;
            r_op           <= 8'd0;
            r_wr           <= 1'b0;
            r_wen          <= 4'b0000;
            r_wdata        <= 32'd0;
            r_wreg         <= 5'd0;
            r_out_valid    <= 1'b0;
            r_out_result   <= 32'd0;
            r_out_wreg     <= 5'd0;
            r_out_exc      <= 2'b00;
            r_out_badvaddr <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.flush) begin
                        r_out_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_out_wreg <= bus.in_wreg;
                        if (!w_is_mem || w_misalign) begin
                            r_out_valid    <= 1'b1;
                            r_out_result   <= w_is_mem ? 32'd0 : bus.in_alu_y;
                            r_out_exc      <= !w_is_mem ? 2'b00 : (w_is_store ? 2'b10 : 2'b01);
                            r_out_badvaddr <= w_is_mem ? bus.in_alu_y : 32'd0;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= S_REQ;
                            r_cnt       <= 8'd0;
                            r_flushed   <= 1'b0;
                            r_addr      <= bus.in_alu_y;
                            r_op        <= bus.in_op;
                            r_wr        <= w_is_store;
                            r_wen       <= w_wen;
                            r_wdata     <= w_wdata;
                            r_wreg      <= bus.in_wreg;
                        end
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_REQ, S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (bus.flush) begin
                        r_flushed   <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                    if (w_done_ok || w_tmo) begin
                        r_state        <= S_IDLE;
                        r_out_valid    <= !(r_flushed || bus.flush);
                        r_out_wreg     <= r_wreg;
                        r_out_result   <= (w_tmo || r_wr) ? 32'd0 : w_load;
                        r_out_exc      <= w_tmo ? 2'b11 : 2'b00;
                        r_out_badvaddr <= w_tmo ? r_addr : 32'd0;
                    end else if ((r_state == S_REQ) && bus.data_addr_ok) begin
                        r_state <= S_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module  : tb_mem_access_unit
// Brief   : Self-checking bench for mem_access_unit against a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;
    localparam int T = 4;
    localparam logic [7:0] ADD = 8'b0010_0000;
    localparam logic [7:0] LB  = 8'b1110_0000;
    localparam logic [7:0] LH  = 8'b1110_0001;
    localparam logic [7:0] LW  = 8'b1110_0011;
    localparam logic [7:0] LBU = 8'b1110_0100;
    localparam logic [7:0] LHU = 8'b1110_0101;
    localparam logic [7:0] SB  = 8'b1110_1000;
    localparam logic [7:0] SH  = 8'b1110_1001;
    localparam logic [7:0] SW  = 8'b1110_1011;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_access_unit_if bus();
    mem_access_unit #(.TIMEOUT_CYC(T)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

    task automatic idle_inputs();
        bus.in_valid = 0; bus.in_op = 0; bus.in_alu_y = 0; bus.in_store = 0; bus.in_wreg = 0;
        bus.flush = 0; bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = 0;
        bus.out_ready = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.out_ready = 0;
        resetn = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.data_req, bus.data_wr, bus.data_wen, bus.data_addr, bus.data_wdata, bus.out_valid,
             bus.out_result, bus.out_wreg, bus.out_exc, bus.out_badvaddr} !== '0)
            begin errors++; $display("FAIL reset_outputs: got nonzero output, required all zero"); end
        checks++;
        if (bus.in_ready !== 1'b1)
            begin errors++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
        resetn = 1;
        bus.out_ready = 1;
    endtask

    // Issue one instruction, act as memory with the given latencies, check the result.
    task automatic run_op(input string nm, input logic [7:0] op, input logic [31:0] y,
                          input logic [31:0] st, input logic [31:0] rdata, input logic [4:0] wreg,
                          input int alat, input int dlat);
        bit ld, sto, mis, tmo;
        int n, nend;
        logic [7:0]  b;
        logic [15:0] h;
        logic [3:0]  ewen;
        logic [31:0] ewd, eres, ebad;
        logic [1:0]  eexc;
        ld  = (op == LB || op == LBU || op == LH || op == LHU || op == LW);
        sto = (op == SB || op == SH || op == SW);
        mis = ((op == LW || op == SW) && y[1:0] != 0) || ((op == LH || op == LHU || op == SH) && y[0]);
        b   = 8'(rdata >> (8 * y[1:0]));
        h   = 16'(rdata >> (16 * y[1]));
        ewen = (op == SB) ? (4'b0001 << y[1:0]) : (op == SH) ? (y[1] ? 4'b1100 : 4'b0011)
             : (op == SW) ? 4'b1111 : 4'b0000;
        ewd  = (op == SB) ? {4{st[7:0]}} : (op == SH) ? {2{st[15:0]}} : st;
        n    = alat + dlat + 1;
        tmo  = (n > T);
        nend = tmo ? T : n;
        if (!ld && !sto)  begin eres = y; eexc = 2'b00; ebad = 0; end
        else if (mis)     begin eres = 0; eexc = sto ? 2'b10 : 2'b01; ebad = y; end
        else if (tmo)     begin eres = 0; eexc = 2'b11; ebad = y; end
        else begin
            eexc = 2'b00; ebad = 0;
            case (op)
                LB:      eres = {{24{b[7]}}, b};
                LBU:     eres = {24'd0, b};
                LH:      eres = {{16{h[15]}}, h};
                LHU:     eres = {16'd0, h};
                LW:      eres = rdata;
                default: eres = 0;
            endcase
        end

        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1)
            begin errors++; $display("FAIL %s in_ready: got %b required 1", nm, bus.in_ready); end
        bus.in_valid = 1; bus.in_op = op; bus.in_alu_y = y; bus.in_store = st; bus.in_wreg = wreg;
        bus.out_ready = 1;
        @(negedge clk);
        bus.in_valid = 0;
        if ((ld || sto) && !mis) begin
            for (int k = 0; k < nend; k++) begin
                checks++;
                if (k <= alat) begin
                    if ({bus.data_req, bus.data_addr, bus.data_wr, bus.data_wen} !== {1'b1, y[31:2], 2'b00, sto, ewen})
                        begin errors++; $display("FAIL %s bus_req c%0d: req=%b addr=%h wr=%b wen=%b required addr=%h wen=%b",
                              nm, k, bus.data_req, bus.data_addr, bus.data_wr, bus.data_wen, {y[31:2], 2'b00}, ewen); end
                    if (sto) begin
                        checks++;
                        if (bus.data_wdata !== ewd)
                            begin errors++; $display("FAIL %s wdata c%0d: got %h required %h", nm, k, bus.data_wdata, ewd); end
                    end
                end else if (bus.data_req !== 1'b0)
                    begin errors++; $display("FAIL %s wait_req c%0d: got %b required 0", nm, k, bus.data_req); end
                bus.data_addr_ok = (k == alat);
                bus.data_data_ok = (k == alat + dlat);
                bus.data_rdata   = (k == alat + dlat) ? rdata : $urandom;
                @(negedge clk);
            end
            bus.data_addr_ok = 0; bus.data_data_ok = 0;
        end
        checks++;
        if ({bus.out_valid, bus.data_req} !== 2'b10)
            begin errors++; $display("FAIL %s out_valid: valid=%b req=%b required valid=1 req=0", nm, bus.out_valid, bus.data_req); end
        checks++;
        if ({bus.out_result, bus.out_exc, bus.out_badvaddr, bus.out_wreg} !== {eres, eexc, ebad, wreg})
            begin errors++; $display("FAIL %s out: result=%h exc=%b bad=%h wreg=%0d required %h %b %h %0d",
                  nm, bus.out_result, bus.out_exc, bus.out_badvaddr, bus.out_wreg, eres, eexc, ebad, wreg); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev;
        prev = 0;
        bus.out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b1)
                begin errors++; $display("FAIL b2b in_ready %0d: got %b required 1", i, bus.in_ready); end
            if (i > 0) begin
                checks++;
                if ({bus.out_valid, bus.out_result} !== {1'b1, prev})
                    begin errors++; $display("FAIL b2b result %0d: valid=%b got %h required %h", i, bus.out_valid, bus.out_result, prev); end
            end
            prev = (i == 0) ? 32'h0000_1234 : $urandom;
            bus.in_valid = 1; bus.in_op = ADD; bus.in_alu_y = prev; bus.in_wreg = 5'(i);
        end
        @(negedge clk);
        bus.in_valid = 0;
        checks++;
        if ({bus.out_valid, bus.out_result} !== {1'b1, prev})
            begin errors++; $display("FAIL b2b last: got %h required %h", bus.out_result, prev); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        bus.out_ready = 0;
        bus.in_valid = 1; bus.in_op = ADD; bus.in_alu_y = 32'hCAFE_0001; bus.in_wreg = 5'd9;
        @(negedge clk);
        bus.in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.out_valid, bus.out_result, bus.in_ready} !== {1'b1, 32'hCAFE_0001, 1'b0})
                begin errors++; $display("FAIL hold %0d: valid=%b result=%h in_ready=%b required 1 cafe0001 0",
                      i, bus.out_valid, bus.out_result, bus.in_ready); end
            @(negedge clk);
        end
        bus.out_ready = 1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL hold_release: got %b required 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        // Flush in IDLE drops a held result and blocks acceptance
        @(negedge clk);
        bus.out_ready = 0;
        bus.in_valid = 1; bus.in_op = ADD; bus.in_alu_y = 32'h55; bus.in_wreg = 5'd1;
        @(negedge clk);
        bus.in_valid = 0; bus.flush = 1;
        checks++;
        if (bus.in_ready !== 1'b0)
            begin errors++; $display("FAIL flush_in_ready: got %b required 0", bus.in_ready); end
        @(negedge clk);
        bus.flush = 0; bus.out_ready = 1;
        checks++;
        if (bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL flush_idle: got %b required 0", bus.out_valid); end
        // Flush in WAIT: handshake completes but result is discarded
        bus.in_valid = 1; bus.in_op = LW; bus.in_alu_y = 32'h40; bus.in_wreg = 5'd2;
        @(negedge clk);
        bus.in_valid = 0; bus.data_addr_ok = 1;
        @(negedge clk);
        bus.data_addr_ok = 0; bus.flush = 1;
        @(negedge clk);
        bus.flush = 0;
        @(negedge clk);
        bus.data_data_ok = 1; bus.data_rdata = 32'h1234_5678;
        @(negedge clk);
        bus.data_data_ok = 0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({bus.out_valid, bus.data_req, bus.in_ready} !== 3'b001)
                begin errors++; $display("FAIL flush_wait %0d: valid=%b req=%b in_ready=%b required 0 0 1",
                      i, bus.out_valid, bus.data_req, bus.in_ready); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_in_req();
        bus.in_valid = 1; bus.in_op = LW; bus.in_alu_y = 32'h80; bus.in_wreg = 5'd3;
        @(negedge clk);
        bus.in_valid = 0;
        checks++;
        if (bus.data_req !== 1'b1)
            begin errors++; $display("FAIL rst_req_pre: got %b required 1", bus.data_req); end
        #2 resetn = 0;
        #1;
        checks++;
        if ({bus.data_req, bus.in_ready} !== 2'b01)
            begin errors++; $display("FAIL rst_req_drop: req=%b in_ready=%b required 0 1", bus.data_req, bus.in_ready); end
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic test_random();
        logic [7:0]  ops [9];
        logic [31:0] y;
        ops = '{ADD, LB, LBU, LH, LHU, LW, SB, SH, SW};
        for (int i = 0; i < 40; i++) begin
            y = $urandom;
            if ($urandom_range(0, 1) == 1) y[1:0] = 2'b00;
            run_op("rand", ops[$urandom_range(0, 8)], y, $urandom, $urandom, 5'($urandom),
                   $urandom_range(0, 1), $urandom_range(0, 1));
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_back_to_back();
        run_op("lb",   LB,  32'h103, 0, 32'h80AA_BBCC, 5'd4, 0, 0);
        run_op("lbu",  LBU, 32'h103, 0, 32'h80AA_BBCC, 5'd5, 0, 0);
        run_op("lh",   LH,  32'h302, 0, 32'h9ABC_0011, 5'd6, 1, 0);
        run_op("sh",   SH,  32'h202, 32'h1234_5678, 0, 5'd7, 2, 1);
        run_op("lw_al", LW, 32'h6, 0, 0, 5'd8, 0, 0);
        run_op("lh_al", LH, 32'h5, 0, 0, 5'd9, 0, 0);
        run_op("sw_al", SW, 32'h1, 32'hFFFF_FFFF, 0, 5'd10, 0, 0);
        run_op("sb",   SB,  32'h3F1, 32'h0000_00A5, 0, 5'd11, 0, 1);
        run_op("lw_edge", LW, 32'h500, 0, 32'hDEAD_BEEF, 5'd12, 1, 2);
        run_op("lw_tmo",  LW, 32'h600, 0, 0, 5'd13, 1000, 0);
        test_backpressure();
        test_flush();
        test_reset_in_req();
        test_random();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
